// File: rtl/tile_ram_arbiter_pkg.sv
// Shared widths, FSM states and issue tags for the tile RAM arbiter.
// STARVE_GUARD_EN (optional) enables the game starvation guard in the top.
package tile_ram_arbiter_pkg;

   localparam int DEF_ADDR_W       = 10;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_STARVE_LIMIT = 16;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   // Tag recorded with each RAM access so its data is routed back one cycle later.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_GAME = 2'd2
   } tag_e;

endpackage

// File: rtl/tile_arb_starve_ctr.sv
// Saturating count of cycles a game request has waited; sat_o forces the next slot.
// Only instantiated when STARVE_GUARD_EN is defined.
module tile_arb_starve_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                                cnt_d = '0;
      else if (inc_i && (cnt_q != CW'(LIMIT)))  cnt_d = cnt_q + 1'b1;
   end

   assign sat_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port tile RAM between the map initialiser, display fetch and game logic.
// Optional STARVE_GUARD_EN: a waiting game access may steal a display slot after STARVE_LIMIT cycles.
module tile_ram_arbiter
   import tile_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
`ifdef STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_ready,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_wdata,
   input  logic              reinit,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_ack,
   output logic [DATA_W-1:0] game_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              running
);

   state_e state_q, state_d;
   tag_e   tag_q, tag_d;
   logic   game_pend, force_game, issue_game, issue_disp, ram_we_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
         tag_q   <= TAG_NONE;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (reinit)                                  state_d = S_INIT;
      else if ((state_q == S_INIT) && init_ready)  state_d = S_RUN;
   end

   // A request held through its own ack cycle is not a new request yet.
   assign game_pend = game_req && (tag_q != TAG_GAME);

   always_comb begin
      issue_game = 1'b0;
      issue_disp = 1'b0;
      if (state_q == S_RUN) begin
         if (game_pend && (force_game || !disp_req)) issue_game = 1'b1;
         else if (disp_req)                          issue_disp = 1'b1;
      end
      ram_addr = disp_addr;
      ram_we_c = 1'b0;
      ram_din  = game_wdata;
      tag_d    = TAG_NONE;
      if (state_q == S_INIT) begin
         ram_addr = init_addr;
         ram_we_c = init_we;
         ram_din  = init_wdata;
      end else if (issue_game) begin
         ram_addr = game_addr;
         ram_we_c = game_we;
         tag_d    = TAG_GAME;
      end else if (issue_disp) begin
         tag_d    = TAG_DISP;
      end
   end

   assign ram_we      = ram_we_c & reset;
   assign running     = (state_q == S_RUN);
   assign disp_rvalid = (tag_q == TAG_DISP);
   assign disp_data   = ram_dout;
   assign game_ack    = (tag_q == TAG_GAME);
   assign game_rdata  = ram_dout;

`ifdef STARVE_GUARD_EN
   tile_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (game_pend && (state_q == S_RUN) && !issue_game),
      .clr_i  (issue_game || (state_q == S_INIT)),
      .sat_o  (force_game)
   );
`else
   assign force_game = 1'b0;
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: RAM model, cycle-level reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_tile_ram_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int LIMIT = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_ready, init_we, reinit;
   logic [AW-1:0] init_addr;
   logic [DW-1:0] init_wdata;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_rvalid;
   logic [DW-1:0] disp_data;
   logic          game_req, game_we;
   logic [AW-1:0] game_addr;
   logic [DW-1:0] game_wdata;
   logic          game_ack;
   logic [DW-1:0] game_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          running;

   int total = 0;
   int bad   = 0;

   tile_ram_arbiter dut (
      .clk(clk), .reset(reset), .init_ready(init_ready), .init_we(init_we),
      .init_addr(init_addr), .init_wdata(init_wdata), .reinit(reinit),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
      .disp_data(disp_data), .game_req(game_req), .game_we(game_we),
      .game_addr(game_addr), .game_wdata(game_wdata), .game_ack(game_ack),
      .game_rdata(game_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout), .running(running)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle synchronous read.
   logic [DW-1:0] ram_mem [1024];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   // Reference model state: expected RAM contents, mode, previous-cycle game service, wait count.
   logic [DW-1:0] shadow [1024];
   bit m_run, m_prev_game;
   int m_wcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: predict from current inputs, advance, then compare outputs.
   task automatic step();
      bit pend, force_g, srv_g, srv_d, g_we;
      logic [DW-1:0] exp_d, exp_g;
      pend    = game_req && !m_prev_game;
`ifdef STARVE_GUARD_EN
      force_g = (m_wcnt >= LIMIT);
`else
      force_g = 1'b0;
`endif
      srv_g = m_run && pend && (!disp_req || force_g);
      srv_d = m_run && disp_req && !srv_g;
      g_we  = game_we;
      exp_d = shadow[disp_addr];
      exp_g = shadow[game_addr];
      if (!m_run && init_we) shadow[init_addr] = init_wdata;
      if (srv_g && game_we)  shadow[game_addr] = game_wdata;
      if (!m_run || srv_g) m_wcnt = 0;
      else if (pend && m_wcnt < LIMIT) m_wcnt++;
      m_prev_game = srv_g;
      m_run = !reinit && (m_run || init_ready);
      @(posedge clk);
      #1;
      chk("disp_rvalid", 32'(disp_rvalid), 32'(srv_d));
      if (srv_d) chk("disp_data", 32'(disp_data), 32'(exp_d));
      chk("game_ack", 32'(game_ack), 32'(srv_g));
      if (srv_g && !g_we) chk("game_rdata", 32'(game_rdata), 32'(exp_g));
      chk("running", 32'(running), 32'(m_run));
   endtask

   typedef struct {
      bit            is_game;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vt [9];

   initial begin
      int first_ack, acks, disp_run;
      vt[0] = '{1'b1, 1'b1, 10'h3FF, 8'hA5, 8'h00};
      vt[1] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 8'hA5};
      vt[2] = '{1'b0, 1'b0, 10'h021, 8'h00, 8'h05};
      vt[3] = '{1'b0, 1'b0, 10'h3FF, 8'h00, 8'hA5};
      vt[4] = '{1'b1, 1'b1, 10'h000, 8'h5A, 8'h00};
      vt[5] = '{1'b0, 1'b0, 10'h000, 8'h00, 8'h5A};
      vt[6] = '{1'b1, 1'b0, 10'h021, 8'h00, 8'h05};
      vt[7] = '{1'b1, 1'b1, 10'h021, 8'h33, 8'h00};
      vt[8] = '{1'b0, 1'b0, 10'h021, 8'h00, 8'h33};

      // Reset with strobes active: nothing may reach RAM or the outputs.
      reset = 1'b0; init_ready = 1'b0; init_we = 1'b1; init_addr = 10'h021;
      init_wdata = 8'h05; reinit = 1'b0; disp_req = 1'b1; disp_addr = 10'h021;
      game_req = 1'b1; game_we = 1'b1; game_addr = 10'h021; game_wdata = 8'hFF;
      m_run = 1'b0; m_prev_game = 1'b0; m_wcnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_ram_we", 32'(ram_we), 32'd0);
      end
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_game_ack", 32'(game_ack), 32'd0);
      chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
      reset = 1'b1;
      game_req = 1'b0;

      // Map load over every cell; display requests must be ignored meanwhile.
      for (int a = 0; a < 1024; a++) begin
         init_addr  = AW'(a);
         init_wdata = (a == 'h21) ? 8'h05 : DW'($urandom);
         disp_req   = 1'($urandom_range(0, 1));
         disp_addr  = AW'($urandom);
         step();
      end
      init_we = 1'b0; init_ready = 1'b1; disp_req = 1'b0;
      step();
      chk("running_after_init", 32'(running), 32'd1);

      // Vector table in blanking / display slots.
      for (int v = 0; v < 9; v++) begin
         if (vt[v].is_game) begin
            game_req = 1'b1; game_we = vt[v].we; game_addr = vt[v].addr;
            game_wdata = vt[v].wdata;
            step();
            chk("vec_game_ack", 32'(game_ack), 32'd1);
            if (!vt[v].we) chk("vec_game_rdata", 32'(game_rdata), 32'(vt[v].exp));
            game_req = 1'b0;
         end else begin
            disp_req = 1'b1; disp_addr = vt[v].addr;
            step();
            chk("vec_disp_rvalid", 32'(disp_rvalid), 32'd1);
            chk("vec_disp_data", 32'(disp_data), 32'(vt[v].exp));
            disp_req = 1'b0;
         end
         step();
      end

      // Write, then a read presented in the ack cycle: ack two cycles after.
      game_req = 1'b1; game_we = 1'b1; game_addr = 10'h155; game_wdata = 8'hC3;
      step();
      chk("wr_ack_t1", 32'(game_ack), 32'd1);
      game_we = 1'b0;
      step();
      chk("rd_no_ack_t2", 32'(game_ack), 32'd0);
      step();
      chk("rd_ack_t3", 32'(game_ack), 32'd1);
      chk("rd_data_t3", 32'(game_rdata), 32'hC3);
      game_req = 1'b0;
      step();

      // Contention: display held for 100 cycles with a game read waiting.
      first_ack = -1;
      game_we = 1'b0; game_addr = 10'h3FF;
      for (int i = 0; i <= 100; i++) begin
         disp_req  = (i < 100);
         disp_addr = AW'($urandom);
         game_req  = (first_ack < 0);
         step();
         if (game_ack && first_ack < 0) first_ack = i;
      end
      game_req = 1'b0; disp_req = 1'b0;
`ifdef STARVE_GUARD_EN
      chk("contention_first_ack", 32'(first_ack), 32'd16);
`else
      chk("contention_first_ack", 32'(first_ack), 32'd100);
`endif
      step();

      // reinit with a game read issued in the same cycle.
      game_req = 1'b1; game_we = 1'b0; game_addr = 10'h021; reinit = 1'b1;
      step();
      chk("reinit_ack", 32'(game_ack), 32'd1);
      chk("reinit_running", 32'(running), 32'd0);
      reinit = 1'b0; init_ready = 1'b0; game_addr = 10'h3FF; disp_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         acks += int'(game_ack) + int'(disp_rvalid);
      end
      chk("reinit_stall", 32'(acks), 32'd0);
      init_ready = 1'b1; disp_req = 1'b0;
      step();
      chk("reinit_rerun", 32'(running), 32'd1);
      step();
      chk("reinit_late_ack", 32'(game_ack), 32'd1);
      chk("reinit_late_data", 32'(game_rdata), 32'hA5);
      game_req = 1'b0;
      step();

      // Randomized traffic: display bursts with blanking gaps, held game requests.
      disp_run = 0;
      for (int c = 0; c < 2000; c++) begin
         if (disp_run == 0) disp_run = $urandom_range(1, 60);
         disp_run--;
         if (disp_run == 0) disp_req = ~disp_req;
         disp_addr = AW'($urandom);
         reinit = ($urandom_range(0, 199) == 0);
         if (!game_req && $urandom_range(0, 2) == 0) begin
            game_req   = 1'b1;
            game_we    = 1'($urandom_range(0, 1));
            game_addr  = AW'($urandom_range(0, 15));
            game_wdata = DW'($urandom);
         end
         step();
         if (game_ack) begin
            game_req   = 1'($urandom_range(0, 1));
            game_we    = 1'($urandom_range(0, 1));
            game_addr  = AW'($urandom_range(0, 15));
            game_wdata = DW'($urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
